// File: rtl/tdoa_locator.sv
// Converts three correlator lags into a 2-D source position using one time-shared multiplier.
// Accepted start -> done after 7 clocks; start is ignored while busy (no queueing).
module tdoa_locator #(
  parameter int W           = 16,
  parameter int SCALE_SHIFT = 3,
  parameter int FRAC        = 12,
  parameter int CX1         = 0,
  parameter int CX2         = 0,
  parameter int CX3         = 655,
  parameter int CY1         = 655,
  parameter int CY2         = 0,
  parameter int CY3         = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] tau1,
  input  logic [W-1:0] tau2,
  input  logic [W-1:0] tau3,
  output logic [W-1:0] xs,
  output logic [W-1:0] ys,
  output logic         done,
  output logic         busy
);

  localparam int TW = W + SCALE_SHIFT;
  localparam int PW = 2 * W + SCALE_SHIFT;
  localparam int AW = PW + 2;
  localparam logic signed [AW-1:0] HALF = AW'(1 << (FRAC - 1));
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic signed [W-1:0]   tau1_q, tau1_d, tau2_q, tau2_d, tau3_q, tau3_d;
  logic signed [AW-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [W-1:0]          xs_q, xs_d, ys_q, ys_d;
  logic                  done_q, done_d;

  logic signed [W-1:0]   coef, tau_sel;
  logic signed [TW-1:0]  tau_scaled;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  prod_ext;

  // Negate, round half toward +inf, then clamp into the W-bit output range.
  function automatic logic [W-1:0] rnd_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = (-acc + HALF) >>> FRAC;
    if (r > SMAX)      return SMAX[W-1:0];
    else if (r < SMIN) return SMIN[W-1:0];
    else               return r[W-1:0];
  endfunction

  // Operand select for the shared multiplier: x products first, then y.
  always_comb begin
    coef    = '0;
    tau_sel = '0;
    case (cnt_q)
      3'd0: begin coef = W'(CX1); tau_sel = tau1_q; end
      3'd1: begin coef = W'(CX2); tau_sel = tau2_q; end
      3'd2: begin coef = W'(CX3); tau_sel = tau3_q; end
      3'd3: begin coef = W'(CY1); tau_sel = tau1_q; end
      3'd4: begin coef = W'(CY2); tau_sel = tau2_q; end
      3'd5: begin coef = W'(CY3); tau_sel = tau3_q; end
      default: begin coef = '0; tau_sel = '0; end
    endcase
    tau_scaled = {{SCALE_SHIFT{tau_sel[W-1]}}, tau_sel} <<< SCALE_SHIFT;
    prod       = $signed({{(PW-W){coef[W-1]}}, coef}) *
                 $signed({{(PW-TW){tau_scaled[TW-1]}}, tau_scaled});
    prod_ext   = $signed({{(AW-PW){prod[PW-1]}}, prod});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tau1_d  = tau1_q;
    tau2_d  = tau2_q;
    tau3_d  = tau3_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tau1_d  = tau1;
          tau2_d  = tau2;
          tau3_d  = tau3;
          acc_x_d = '0;
          acc_y_d = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (cnt_q < 3'd3) acc_x_d = acc_x_q + prod_ext;
        else              acc_y_d = acc_y_q + prod_ext;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_d = FIN;
      end
      FIN: begin
        xs_d    = rnd_sat(acc_x_q);
        ys_d    = rnd_sat(acc_y_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tau1_q  <= '0;
      tau2_q  <= '0;
      tau3_q  <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tau1_q  <= tau1_d;
      tau2_q  <= tau2_d;
      tau3_q  <= tau3_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      done_q  <= done_d;
    end
  end

  assign xs   = xs_q;
  assign ys   = ys_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tdoa_locator.sv
// Bench for tdoa_locator: default-coefficient instance plus a saturating-coefficient instance.
module tb_tdoa_locator;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_start, s_start;
  logic [15:0] d_tau1, d_tau2, d_tau3, s_tau1, s_tau2, s_tau3;
  logic [15:0] d_xs, d_ys, s_xs, s_ys;
  logic        d_done, d_busy, s_done, s_busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit sat;
    int t1, t2, t3;
    int ex, ey;
  } vec_t;

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  tdoa_locator u_dut (
    .clk(clk), .rst(rst), .start(d_start),
    .tau1(d_tau1), .tau2(d_tau2), .tau3(d_tau3),
    .xs(d_xs), .ys(d_ys), .done(d_done), .busy(d_busy)
  );

  tdoa_locator #(.CX3(32767), .CY1(32767)) u_sat (
    .clk(clk), .rst(rst), .start(s_start),
    .tau1(s_tau1), .tau2(s_tau2), .tau3(s_tau3),
    .xs(s_xs), .ys(s_ys), .done(s_done), .busy(s_busy)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Drive one computation, queue its expectation, wait (bounded) for done and score it.
  task automatic run_vec(input bit sat, input int t1, input int t2, input int t3,
                         input int ex, input int ey, input string nm);
    exp_t e;
    int   lat;
    bit   got;
    e.x = ex;
    e.y = ey;
    sb.push_back(e);
    @(negedge clk);
    if (sat) begin
      s_start = 1'b1; s_tau1 = 16'(t1); s_tau2 = 16'(t2); s_tau3 = 16'(t3);
    end else begin
      d_start = 1'b1; d_tau1 = 16'(t1); d_tau2 = 16'(t2); d_tau3 = 16'(t3);
    end
    @(negedge clk);
    d_start = 1'b0;
    s_start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (sat ? s_done : d_done) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    e = sb.pop_front();
    if (got) begin
      chk({nm, "_latency"}, lat, 7);
      chk({nm, "_xs"}, int'($signed(sat ? s_xs : d_xs)), e.x);
      chk({nm, "_ys"}, int'($signed(sat ? s_ys : d_ys)), e.y);
      chk({nm, "_busy"}, int'(sat ? s_busy : d_busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0,     -5,    0,     10,   -13,      6};
    vecs[1] = '{0,      0,    0,      0,     0,      0};
    vecs[2] = '{0,      0,    0,    -10,    13,      0};
    vecs[3] = '{0,    100,    0,   -100,   128,   -128};
    vecs[4] = '{0,      0, 1234,      0,     0,      0};
    vecs[5] = '{0,      1,    0,      1,    -1,     -1};
    vecs[6] = '{0,  32767,    0,  32767, -32768, -32768};
    vecs[7] = '{0, -32768,    0, -32768,  32767,  32767};
    vecs[8] = '{1,  32767,    0,  32767, -32768, -32768};
    vecs[9] = '{1, -32768,    0, -32768,  32767,  32767};

    rst = 1'b1;
    d_start = 1'b0; s_start = 1'b0;
    d_tau1 = '0; d_tau2 = '0; d_tau3 = '0;
    s_tau1 = '0; s_tau2 = '0; s_tau3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    chk("rst_xs",   int'($signed(d_xs)), 0);
    chk("rst_ys",   int'($signed(d_ys)), 0);
    chk("rst_done", int'(d_done), 0);
    chk("rst_busy", int'(d_busy), 0);
    chk("rst_sat_busy", int'(s_busy), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_vec(vecs[i].sat, vecs[i].t1, vecs[i].t2, vecs[i].t3,
              vecs[i].ex, vecs[i].ey, $sformatf("vec%0d", i));
    run_vec(1'b1, 1, 0, 1, -64, -64, "sat_small");

    // Handshake: busy/done through E0..E6, ignored start mid-MAC, input changes after E0
    @(negedge clk);
    d_start = 1'b1; d_tau1 = 16'(-5); d_tau2 = 16'(0); d_tau3 = 16'(10);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("hs_busy_e%0d", k), int'(d_busy), 1);
      chk($sformatf("hs_done_e%0d", k), int'(d_done), 0);
      d_start = (k == 2);
      d_tau3  = 16'(100 + k);
    end
    @(negedge clk);
    chk("hs_done_e7", int'(d_done), 1);
    chk("hs_busy_e7", int'(d_busy), 0);
    chk("hs_xs", int'($signed(d_xs)), -13);
    chk("hs_ys", int'($signed(d_ys)), 6);
    d_tau1 = 16'(77);
    repeat (5) @(negedge clk);
    chk("hs_done_hold", int'(d_done), 1);
    chk("hs_busy_hold", int'(d_busy), 0);
    chk("hs_xs_hold", int'($signed(d_xs)), -13);

    // Reset mid-MAC: rst sampled at E3
    d_start = 1'b1; d_tau1 = 16'(-5); d_tau2 = 16'(0); d_tau3 = 16'(10);
    @(negedge clk);
    d_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_xs",   int'($signed(d_xs)), 0);
    chk("mid_rst_ys",   int'($signed(d_ys)), 0);
    chk("mid_rst_done", int'(d_done), 0);
    chk("mid_rst_busy", int'(d_busy), 0);
    repeat (10) @(negedge clk);
    chk("mid_rst_no_result", int'(d_done), 0);
    chk("mid_rst_xs_quiet", int'($signed(d_xs)), 0);
    run_vec(1'b0, -5, 0, 10, -13, 6, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
